// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if: issue bus from the stage sequencer to the butterfly datapath.
// master = sequencer (drives the issue), slave = datapath read side.
interface fft_stage_sequencer_if;
    logic       o_valid;
    logic [7:0] o_addr1;
    logic [7:0] o_addr2;
    logic [9:0] o_stride;
    logic [8:0] o_twiddle_offset1;
    logic [8:0] o_twiddle_offset2;
    logic [8:0] o_twiddle_offset3;
    logic [8:0] o_twiddle_offset4;
    logic [3:0] o_stage;

    modport master (
        output o_valid, o_addr1, o_addr2, o_stride,
        output o_twiddle_offset1, o_twiddle_offset2, o_twiddle_offset3, o_twiddle_offset4,
        output o_stage
    );
    modport slave (
        input o_valid, o_addr1, o_addr2, o_stride,
        input o_twiddle_offset1, o_twiddle_offset2, o_twiddle_offset3, o_twiddle_offset4,
        input o_stage
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: issue-side controller for the 1024-point in-place radix-2 FFT.
// Walks 10 stages x 128 word-pair issues, waits for every write-back of a stage
// before starting the next one, and flags unexpected write-backs.
// Optional feature macro: FFT_SEQ_INVERSE_EN (adds i_inverse, conjugate twiddles).
module fft_stage_sequencer #(
    parameter int NUM_STAGES       = 10,
    parameter int ISSUES_PER_STAGE = 128
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_stall,
    input  logic i_wb_valid,
`ifdef FFT_SEQ_INVERSE_EN
    input  logic i_inverse,
`endif
    fft_stage_sequencer_if.master issue,
    output logic o_busy,
    output logic o_done,
    output logic o_err
);
    localparam logic [6:0] J_LAST  = 7'(ISSUES_PER_STAGE - 1);
    localparam logic [7:0] WB_FULL = 8'(ISSUES_PER_STAGE);
    localparam logic [3:0] S_LAST  = 4'(NUM_STAGES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state_q;
    logic [6:0]      j_q;
    logic [3:0]      s_q;
    logic [7:0]      wb_q;
    logic            bubble_q;   // one idle ISSUE cycle after a stage turnaround
`ifdef FFT_SEQ_INVERSE_EN
    logic            inv_q;
`endif
    logic            valid_q, busy_q, done_q, err_q;
    logic [7:0]      addr1_q, addr2_q;
    logic [9:0]      stride_q;
    logic [3:0][8:0] tw_q;

    logic [3:0]      sh_d;
    logic [7:0]      span_d, addr1_d, addr2_d;
    logic [9:0]      stride_d;
    logic [3:0][9:0] p_d;
    logic [3:0][8:0] tw_d;
    logic            wb_hit;

    // Address, stride and twiddle offsets for issue j_q of stage s_q
    always_comb begin
        sh_d     = s_q - 4'd2;
        span_d   = 8'd1 << sh_d;
        stride_d = 10'd1 << s_q;
        if (s_q <= 4'd2) begin
            addr1_d = {j_q, 1'b0};
            addr2_d = {j_q, 1'b1};
        end else begin
            addr1_d = (({1'b0, j_q} >> sh_d) << (sh_d + 4'd1)) | ({1'b0, j_q} & (span_d - 8'd1));
            addr2_d = addr1_d + span_d;
        end
        p_d  = '0;
        tw_d = '0;
        for (int b = 0; b < 4; b++) begin
            // Early stages pack several butterflies into one word pair
            case (s_q)
                4'd0:    p_d[b] = {addr1_d, 2'b00} + 10'(2 * b);
                4'd1:    p_d[b] = {addr1_d, 2'b00} + 10'((b % 2) + 4 * (b / 2));
                default: p_d[b] = {addr1_d, 2'b00} + 10'(b);
            endcase
            tw_d[b] = 9'((p_d[b] & (stride_d - 10'd1)) << (4'd9 - s_q));
`ifdef FFT_SEQ_INVERSE_EN
            if (inv_q) tw_d[b] = 9'd0 - tw_d[b];
`endif
        end
    end

    // The stage is drained once 128 write-backs are in, counting this cycle's
    assign wb_hit = (wb_q == WB_FULL) || (i_wb_valid && (wb_q == WB_FULL - 8'd1));

    // Control FSM with registered issue outputs and write-back accounting
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            j_q      <= '0;
            s_q      <= '0;
            wb_q     <= '0;
            bubble_q <= 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
            inv_q    <= 1'b0;
`endif
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            addr1_q  <= '0;
            addr2_q  <= '0;
            stride_q <= '0;
            tw_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (i_wb_valid) begin
                if ((state_q == ISSUE || state_q == DRAIN) && wb_q != WB_FULL) wb_q <= wb_q + 8'd1;
                else err_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (i_start) begin
                    j_q      <= '0;
                    s_q      <= '0;
                    wb_q     <= '0;
                    bubble_q <= 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
                    inv_q    <= i_inverse;
`endif
                    busy_q   <= 1'b1;
                    state_q  <= ISSUE;
                end
                ISSUE: begin
                    if (bubble_q) begin
                        bubble_q <= 1'b0;
                    end else if (!i_stall) begin
                        valid_q  <= 1'b1;
                        addr1_q  <= addr1_d;
                        addr2_q  <= addr2_d;
                        stride_q <= stride_d;
                        tw_q     <= tw_d;
                        j_q      <= j_q + 7'd1;
                        if (j_q == J_LAST) state_q <= DRAIN;
                    end
                end
                DRAIN: if (wb_hit) begin
                    if (s_q == S_LAST) begin
                        state_q <= DONE;
                    end else begin
                        s_q      <= s_q + 4'd1;
                        j_q      <= '0;
                        wb_q     <= '0;
                        bubble_q <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign issue.o_valid           = valid_q;
    assign issue.o_addr1           = addr1_q;
    assign issue.o_addr2           = addr2_q;
    assign issue.o_stride          = stride_q;
    assign issue.o_twiddle_offset1 = tw_q[0];
    assign issue.o_twiddle_offset2 = tw_q[1];
    assign issue.o_twiddle_offset3 = tw_q[2];
    assign issue.o_twiddle_offset4 = tw_q[3];
    assign issue.o_stage           = s_q;
    assign o_busy                  = busy_q;
    assign o_done                  = done_q;
    assign o_err                   = err_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: randomized bench for the FFT stage sequencer with a
// closed-form reference model and a 5-cycle write-back loopback.
module tb_fft_stage_sequencer;
    typedef struct packed {
        logic [3:0] stage;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [9:0] stride;
        logic [8:0] t0;
        logic [8:0] t1;
        logic [8:0] t2;
        logic [8:0] t3;
    } iss_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0, stray_wb = 1'b0;
    logic inverse = 1'b0;
    logic loop_en = 1'b1;
    logic [4:0] wb_pipe = '0;
    wire  wb_valid = wb_pipe[4] | stray_wb;
    logic busy, done, err;
    int   cyc = 0, n_checks = 0, n_fail = 0;
    int   done_cnt = 0, done_edge = 0, start_edge = 0;
    logic done_busy = 1'b1;
    iss_t cap_q[$];
    int   cap_edge[$];
    iss_t mon_c;

    fft_stage_sequencer_if ifc();

    fft_stage_sequencer dut (
        .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stall(stall), .i_wb_valid(wb_valid),
`ifdef FFT_SEQ_INVERSE_EN
        .i_inverse(inverse),
`endif
        .issue(ifc), .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture issues and done pulses; loop every issue back as a write-back 5 edges later
    always @(negedge clk) begin
        if (ifc.o_valid) begin
            mon_c = {ifc.o_stage, ifc.o_addr1, ifc.o_addr2, ifc.o_stride, ifc.o_twiddle_offset1,
                     ifc.o_twiddle_offset2, ifc.o_twiddle_offset3, ifc.o_twiddle_offset4};
            cap_q.push_back(mon_c);
            cap_edge.push_back(cyc);
        end
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_edge = cyc;
            done_busy = busy;
        end
        wb_pipe = {wb_pipe[3:0], ifc.o_valid & loop_en};
    end

    // Reference: issue j of stage s straight from the address/twiddle rules
    function automatic iss_t model(input int s, input int j, input logic inv);
        iss_t r;
        int a1, d, off;
        int t[4];
        d = 1 << s;
        if (s <= 2) a1 = 2 * j;
        else a1 = (j / (1 << (s - 2))) * (1 << (s - 1)) + j % (1 << (s - 2));
        r.stage  = 4'(s);
        r.a1     = 8'(a1);
        r.a2     = 8'((s <= 2) ? a1 + 1 : a1 + (1 << (s - 2)));
        r.stride = 10'(d);
        for (int b = 0; b < 4; b++) begin
            if (s == 0) off = 2 * b;
            else if (s == 1) off = (b % 2) + 4 * (b / 2);
            else off = b;
            t[b] = ((4 * a1 + off) % d) * (512 / d);
            if (inv) t[b] = (512 - t[b]) % 512;
        end
        r.t0 = 9'(t[0]); r.t1 = 9'(t[1]); r.t2 = 9'(t[2]); r.t3 = 9'(t[3]);
        return r;
    endfunction

    function automatic logic inv_eff();
`ifdef FFT_SEQ_INVERSE_EN
        return inverse;
`else
        return 1'b0;
`endif
    endfunction

    // Stimulus: start one transform; mode 0 = no stall, 1 = one 3-cycle stall burst
    // mid stage 0, 2 = random stalls plus stray i_start pulses
    task automatic run_transform(input int mode, output bit timed_out);
        int burst_at, stall_left;
        cap_q.delete();
        cap_edge.delete();
        done_cnt   = 0;
        done_busy  = 1'b1;
        burst_at   = $urandom_range(20, 100);
        stall_left = 0;
        timed_out  = 1'b1;
        @(negedge clk);
        start = 1'b1;
        start_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (done) begin timed_out = 1'b0; break; end
            stall = 1'b0;
            if (mode == 1) begin
                if (stall_left == 0 && burst_at > 0 && cap_q.size() == burst_at) begin
                    stall_left = 3;
                    burst_at   = 0;
                end
                if (stall_left > 0) begin stall = 1'b1; stall_left--; end
            end else if (mode == 2) begin
                stall = ($urandom_range(0, 2) == 0);
                start = ($urandom_range(0, 15) == 0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        stall = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ifc.o_stride !== 10'd0) begin
            n_fail++; $display("FAIL reset_stride: got %0d expected 0", ifc.o_stride);
        end
        n_checks++;
        if ({ifc.o_valid, ifc.o_addr1, ifc.o_addr2, ifc.o_twiddle_offset1, ifc.o_twiddle_offset2,
             ifc.o_twiddle_offset3, ifc.o_twiddle_offset4, ifc.o_stage, busy, done, err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: valid=%b a1=%0d a2=%0d stage=%0d busy=%b done=%b err=%b expected all 0",
                               ifc.o_valid, ifc.o_addr1, ifc.o_addr2, ifc.o_stage, busy, done, err);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ifc.o_valid, busy, err} !== 3'b000) begin
            n_fail++; $display("FAIL idle_after_reset: valid=%b busy=%b err=%b expected 0 0 0", ifc.o_valid, busy, err);
        end
    endtask

    task automatic test_full_run();
        bit to;
        iss_t exp;
        inverse = 1'b0;
        run_transform(0, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL full_timeout: no o_done within budget"); end
        n_checks++;
        if (cap_q.size() != 1280) begin
            n_fail++; $display("FAIL full_count: got %0d issues expected 1280", cap_q.size());
        end else begin
            for (int i = 0; i < 1280; i++) begin
                exp = model(i / 128, i % 128, 1'b0);
                n_checks++;
                if (cap_q[i] !== exp) begin
                    n_fail++; $display("FAIL full_issue[%0d]: got %h expected %h", i, cap_q[i], exp);
                end
            end
            n_checks++;
            if (cap_edge[0] != start_edge + 1) begin
                n_fail++; $display("FAIL start_latency: first issue edge %0d expected %0d", cap_edge[0], start_edge + 1);
            end
            for (int s = 0; s < 10; s++) begin
                n_checks++;
                if (cap_edge[s * 128 + 127] - cap_edge[s * 128] != 127) begin
                    n_fail++; $display("FAIL stage_span[%0d]: got %0d expected 127", s, cap_edge[s * 128 + 127] - cap_edge[s * 128]);
                end
                if (s > 0) begin
                    n_checks++;
                    if (cap_edge[s * 128] != cap_edge[s * 128 - 1] + 7) begin
                        n_fail++; $display("FAIL turnaround[%0d]: got edge %0d expected %0d", s, cap_edge[s * 128], cap_edge[s * 128 - 1] + 7);
                    end
                end
            end
            n_checks++;
            if (done_edge != cap_edge[1279] + 6) begin
                n_fail++; $display("FAIL done_timing: got edge %0d expected %0d", done_edge, cap_edge[1279] + 6);
            end
            exp = {4'd0, 8'd10, 8'd11, 10'd1, 9'd0, 9'd0, 9'd0, 9'd0};
            n_checks++;
            if (cap_q[5] !== exp) begin n_fail++; $display("FAIL vec_s0_j5: got %h expected %h", cap_q[5], exp); end
            exp = {4'd2, 8'd0, 8'd1, 10'd4, 9'd0, 9'd128, 9'd256, 9'd384};
            n_checks++;
            if (cap_q[256] !== exp) begin n_fail++; $display("FAIL vec_s2_j0: got %h expected %h", cap_q[256], exp); end
            exp = {4'd3, 8'd1, 8'd3, 10'd8, 9'd256, 9'd320, 9'd384, 9'd448};
            n_checks++;
            if (cap_q[385] !== exp) begin n_fail++; $display("FAIL vec_s3_j1: got %h expected %h", cap_q[385], exp); end
            exp = {4'd9, 8'd127, 8'd255, 10'd512, 9'd508, 9'd509, 9'd510, 9'd511};
            n_checks++;
            if (cap_q[1279] !== exp) begin n_fail++; $display("FAIL vec_s9_j127: got %h expected %h", cap_q[1279], exp); end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_count: got %0d expected 1", done_cnt); end
        n_checks++;
        if (done_busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b expected 0", done_busy); end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b expected 0", err); end
        n_checks++;
        if ({ifc.o_valid, ifc.o_addr1, ifc.o_addr2, ifc.o_stride} !== {1'b0, 8'd127, 8'd255, 10'd512}) begin
            n_fail++; $display("FAIL hold_after_done: valid=%b a1=%0d a2=%0d stride=%0d expected 0 127 255 512",
                               ifc.o_valid, ifc.o_addr1, ifc.o_addr2, ifc.o_stride);
        end
    endtask

    task automatic test_stall();
        bit to;
        iss_t exp;
        inverse = 1'b0;
        run_transform(1, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL stall_timeout: no o_done within budget"); end
        n_checks++;
        if (cap_q.size() != 1280) begin
            n_fail++; $display("FAIL stall_count: got %0d issues expected 1280", cap_q.size());
        end else begin
            for (int i = 0; i < 1280; i++) begin
                exp = model(i / 128, i % 128, 1'b0);
                n_checks++;
                if (cap_q[i] !== exp) begin
                    n_fail++; $display("FAIL stall_issue[%0d]: got %h expected %h", i, cap_q[i], exp);
                end
            end
            n_checks++;
            if (cap_edge[127] - cap_edge[0] != 130) begin
                n_fail++; $display("FAIL stall_span0: got %0d expected 130", cap_edge[127] - cap_edge[0]);
            end
            n_checks++;
            if (cap_edge[255] - cap_edge[128] != 127) begin
                n_fail++; $display("FAIL stall_span1: got %0d expected 127", cap_edge[255] - cap_edge[128]);
            end
        end
        n_checks++;
        if (done_cnt != 1 || err !== 1'b0) begin
            n_fail++; $display("FAIL stall_done_err: done_cnt=%0d err=%b expected 1 0", done_cnt, err);
        end
    endtask

    task automatic test_random_stall();
        bit to;
        iss_t exp;
        inverse = 1'($urandom_range(0, 1));
        run_transform(2, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL rnd_timeout: no o_done within budget"); end
        n_checks++;
        if (cap_q.size() != 1280) begin
            n_fail++; $display("FAIL rnd_count: got %0d issues expected 1280", cap_q.size());
        end else begin
            for (int i = 0; i < 1280; i++) begin
                exp = model(i / 128, i % 128, inv_eff());
                n_checks++;
                if (cap_q[i] !== exp) begin
                    n_fail++; $display("FAIL rnd_issue[%0d]: got %h expected %h", i, cap_q[i], exp);
                end
            end
`ifdef FFT_SEQ_INVERSE_EN
            if (inverse) begin
                exp = {4'd2, 8'd0, 8'd1, 10'd4, 9'd0, 9'd384, 9'd256, 9'd128};
                n_checks++;
                if (cap_q[256] !== exp) begin n_fail++; $display("FAIL vec_inv_s2_j0: got %h expected %h", cap_q[256], exp); end
            end
`endif
        end
        n_checks++;
        if (done_cnt != 1 || err !== 1'b0) begin
            n_fail++; $display("FAIL rnd_done_err: done_cnt=%0d err=%b expected 1 0", done_cnt, err);
        end
        inverse = 1'b0;
    endtask

    task automatic test_reset_midrun();
        bit hit, to;
        iss_t exp;
        hit = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (ifc.o_stage == 4'd4 && ifc.o_valid) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!hit) begin n_fail++; $display("FAIL midrun_reach_stage4: stage 4 never issued"); end
        repeat ($urandom_range(1, 60)) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ifc.o_valid, ifc.o_addr1, ifc.o_addr2, ifc.o_stride, ifc.o_stage, busy, done, err} !== '0) begin
            n_fail++; $display("FAIL midrun_reset_outputs: valid=%b a1=%0d stride=%0d stage=%0d busy=%b err=%b expected all 0",
                               ifc.o_valid, ifc.o_addr1, ifc.o_stride, ifc.o_stage, busy, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray_wb = 1'b1;
        @(negedge clk);
        stray_wb = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if ({ifc.o_valid, ifc.o_addr1, ifc.o_addr2, ifc.o_stride, ifc.o_twiddle_offset1, ifc.o_twiddle_offset2,
             ifc.o_twiddle_offset3, ifc.o_twiddle_offset4, ifc.o_stage, busy, done} !== '0) begin
            n_fail++; $display("FAIL stray_outputs: valid=%b a1=%0d stride=%0d stage=%0d busy=%b done=%b expected all 0",
                               ifc.o_valid, ifc.o_addr1, ifc.o_stride, ifc.o_stage, busy, done);
        end
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL stray_err: got %b expected 1", err); end
        run_transform(0, to);
        n_checks++;
        if (to || cap_q.size() != 1280 || done_cnt != 1) begin
            n_fail++; $display("FAIL rerun_basic: timeout=%b issues=%0d done_cnt=%0d expected 0 1280 1", to, cap_q.size(), done_cnt);
        end else begin
            for (int i = 0; i < 1280; i++) begin
                exp = model(i / 128, i % 128, 1'b0);
                n_checks++;
                if (cap_q[i] !== exp) begin
                    n_fail++; $display("FAIL rerun_issue[%0d]: got %h expected %h", i, cap_q[i], exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_stall();
        test_random_stall();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
